// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) unit, one bit per cycle.
// Optional macro MULTDIV_UNSIGNED_EN adds is_unsigned for MULTU/DIVU.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
`ifdef MULTDIV_UNSIGNED_EN
    input  logic             is_unsigned,
`endif
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;

    // Booth accumulator: {upper W+1 bits, multiplier W bits, q(-1)}.
    // The extra upper bit keeps -2^(W-1) multiplicands from overflowing the add/sub.
    localparam int AW = 2*WIDTH + 2;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [AW-1:0]         acc, acc_nxt;
    logic [WIDTH:0]        mcand;
    logic [WIDTH-1:0]      rem, quo, dvsr, rem_nxt, quo_nxt;
    logic                  op_div, dz, neg_q, neg_r, uns_op, mplr_msb;
    logic                  uns_in, last;
    logic [WIDTH-1:0]      abs_a, abs_b, hi_fix;
    logic [WIDTH:0]        upper, sum, shifted, diff;
    logic signed [AW-1:0]  stepped;

`ifdef MULTDIV_UNSIGNED_EN
    assign uns_in = is_unsigned;
`else
    assign uns_in = 1'b0;
`endif

    assign busy  = (state != IDLE);
    assign last  = (cnt == CNT_W'(WIDTH-1));
    assign abs_a = (A[WIDTH-1] && !uns_in) ? -A : A;
    assign abs_b = (B[WIDTH-1] && !uns_in) ? -B : B;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_mult)     state_nxt = MULT;
                else if (start_div) state_nxt = (B == '0) ? FINISH : DIV;
            end
            MULT:    if (last) state_nxt = FINISH;
            DIV:     if (last) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One Booth step: add/sub multiplicand on the upper half, then arithmetic shift right.
    always_comb begin
        upper = acc[AW-1 -: WIDTH+1];
        case (acc[1:0])
            2'b01:   sum = upper + mcand;
            2'b10:   sum = upper - mcand;
            default: sum = upper;
        endcase
        stepped = $signed({sum, acc[WIDTH:0]});
        acc_nxt = AW'(stepped >>> 1);
    end

    // One restoring step; the shifted remainder needs W+1 bits before the trial subtract.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, dvsr};
        rem_nxt = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_nxt = {quo[WIDTH-2:0], ~diff[WIDTH]};
    end

    // Booth treats the multiplier as signed; an unsigned multiplier with its MSB set
    // is short by A*2^W, restored on the high word.
    assign hi_fix = acc[2*WIDTH:WIDTH+1] +
                    ((uns_op && mplr_msb) ? mcand[WIDTH-1:0] : '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            rem      <= '0;
            quo      <= '0;
            dvsr     <= '0;
            op_div   <= 1'b0;
            dz       <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            uns_op   <= 1'b0;
            mplr_msb <= 1'b0;
            HI       <= '0;
            LO       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start_mult) begin
                        mcand    <= uns_in ? {1'b0, A} : {A[WIDTH-1], A};
                        acc      <= {{(WIDTH+1){1'b0}}, B, 1'b0};
                        mplr_msb <= B[WIDTH-1];
                        uns_op   <= uns_in;
                        op_div   <= 1'b0;
                        dz       <= 1'b0;
                    end else if (start_div) begin
                        op_div <= 1'b1;
                        uns_op <= uns_in;
                        dz     <= (B == '0);
                        rem    <= '0;
                        quo    <= abs_a;
                        dvsr   <= abs_b;
                        neg_q  <= !uns_in && (A[WIDTH-1] ^ B[WIDTH-1]);
                        neg_r  <= !uns_in && A[WIDTH-1];
                    end
                end
                MULT: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 1'b1;
                end
                DIV: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt + 1'b1;
                end
                FINISH: begin
                    done <= 1'b1;
                    if (dz) begin
                        div_zero <= 1'b1;
                    end else if (op_div) begin
                        LO <= neg_q ? -quo : quo;
                        HI <= neg_r ? -rem : rem;
                    end else begin
                        HI <= hi_fix;
                        LO <= acc[WIDTH:1];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
